// File: rtl/dp_pkg.sv
// Shared dot-product datapath types and the requantisation rule used by every
// stage that turns a wide accumulator into a signed 8-bit result.
package dp_pkg;

  localparam int SUM_W   = 10;
  localparam int OUT_W   = 8;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;
  localparam int SHIFT_W = 4;

  typedef logic signed [SUM_W-1:0] tree_sum_t;
  typedef logic signed [OUT_W-1:0] q_out_t;

  // Optional ReLU, round-half-up arithmetic shift, saturation to OUT_W bits.
  // Callers sign-extend their pre-shift value to 32 bits; two guard bits keep
  // the rounding add from overflowing.
  function automatic q_out_t requant(input logic signed [31:0] r,
                                     input logic [SHIFT_W-1:0] shift,
                                     input logic               relu_en);
    logic signed [33:0] v;
    v = 34'(r);
    v = (relu_en && (v < 34'sd0)) ? 34'sd0 : v;
    if (shift != 4'd0) begin
      v = (v + (34'sd1 <<< (shift - 4'd1))) >>> shift;
    end else begin
      v = v + 34'sd0;
    end
    if (v > 34'(OUT_MAX)) begin
      requant = q_out_t'(OUT_MAX);
    end else if (v < 34'(OUT_MIN)) begin
      requant = q_out_t'(OUT_MIN);
    end else begin
      requant = q_out_t'(v[OUT_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always visible on pop_data.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Width-1:0] mem_r [Depth];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(Depth));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tree_accum_requant_chk.sv
// Invariant checks for tree_accum_requant: the issue credit must keep the FIFO
// from ever seeing a push while full.
module tree_accum_requant_chk (
  input logic clk_in,
  input logic rst_n_in,
  input logic push,
  input logic full
);

  a_no_fifo_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                       !(push && full));

endmodule

// File: rtl/tree_accum_requant.sv
// Accumulates NumChunks adder-tree partial sums, adds bias, requantises to int8
// and buffers results; issue credit stops the non-stallable tree overrunning the FIFO.
module tree_accum_requant
  import dp_pkg::*;
#(
  parameter int TreeLatency = 3,
  parameter int NumChunks   = 4,
  parameter int AccWidth    = 16,
  parameter int FifoDepth   = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                issue_valid_in,
  output logic                issue_ready_out,
  input  logic [SUM_W-1:0]    sum_in,
  input  logic [AccWidth-1:0] bias_in,
  input  logic [3:0]          shift_in,
  input  logic                relu_en_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data
);

  localparam int CW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int FW = $clog2(FifoDepth) + 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NumChunks - 1);

  logic                       issue_s;
  logic                       last_issue_s;
  logic [CW-1:0]              issue_cnt_r;
  logic [TreeLatency-1:0]     delay_r;
  logic                       aligned_v_s;
  logic [CW-1:0]              acc_cnt_r;
  logic signed [AccWidth-1:0] acc_r;
  logic                       done_r;
  logic [FW-1:0]              pending_r;
  logic [FW-1:0]              count_s;
  logic [FW:0]                credit_s;
  logic                       full_s;
  logic                       pop_s;
  tree_sum_t                  sum_s;
  logic signed [AccWidth-1:0] sext_s;
  logic signed [AccWidth-1:0] bias_s;
  logic signed [AccWidth:0]   r_s;
  q_out_t                     q_s;

  assign issue_s      = issue_valid_in & issue_ready_out;
  assign last_issue_s = issue_s & (issue_cnt_r == LAST_CHUNK);
  assign aligned_v_s  = delay_r[TreeLatency-1];

  // Results already buffered plus groups still in flight must fit in the FIFO.
  assign credit_s        = {1'b0, count_s} + {1'b0, pending_r};
  assign issue_ready_out = (credit_s < (FW+1)'(FifoDepth));
  assign out_valid       = (count_s != {FW{1'b0}});
  assign pop_s           = out_valid & out_ready;

  assign sum_s  = sum_in;
  assign sext_s = AccWidth'(sum_s);
  assign bias_s = bias_in;
  assign r_s    = (AccWidth+1)'(acc_r) + (AccWidth+1)'(bias_s);
  assign q_s    = requant(32'(r_s), shift_in, relu_en_in);

  // Issue-side chunk position.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issue_cnt_r <= {CW{1'b0}};
    end else if (issue_s) begin
      issue_cnt_r <= (issue_cnt_r == LAST_CHUNK) ? {CW{1'b0}} : issue_cnt_r + CW'(1);
    end else begin
      issue_cnt_r <= issue_cnt_r;
    end
  end

  // Issue bit travels alongside the tree so its tail marks a valid sum_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      delay_r <= {TreeLatency{1'b0}};
    end else begin
      delay_r[0] <= issue_s;
      for (int i = 1; i < TreeLatency; i++) begin
        delay_r[i] <= delay_r[i-1];
      end
    end
  end

  // Accumulator; chunk 0 restarts the sum, the last chunk raises done.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_r     <= {AccWidth{1'b0}};
      acc_cnt_r <= {CW{1'b0}};
      done_r    <= 1'b0;
    end else if (aligned_v_s) begin
      acc_r     <= (acc_cnt_r == {CW{1'b0}}) ? sext_s : acc_r + sext_s;
      acc_cnt_r <= (acc_cnt_r == LAST_CHUNK) ? {CW{1'b0}} : acc_cnt_r + CW'(1);
      done_r    <= (acc_cnt_r == LAST_CHUNK);
    end else begin
      acc_r     <= acc_r;
      acc_cnt_r <= acc_cnt_r;
      done_r    <= 1'b0;
    end
  end

  // Groups issued but not yet written to the FIFO.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_r <= {FW{1'b0}};
    end else begin
      case ({last_issue_s, done_r})
        2'b10:   pending_r <= pending_r + FW'(1);
        2'b01:   pending_r <= pending_r - FW'(1);
        default: pending_r <= pending_r;
      endcase
    end
  end

  sync_fifo #(
    .Width (OUT_W),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (done_r),
    .push_data (q_s),
    .pop       (pop_s),
    .pop_data  (out_data),
    .count     (count_s),
    .full      (full_s)
  );

  tree_accum_requant_chk u_chk (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (done_r),
    .full     (full_s)
  );

endmodule
